// File: rtl/adc_capture_pkg.sv
// Shared state encoding, word layout and field helpers for the ADC
// trigger capture buffer.
package adc_capture_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    READ  = 3'd4
  } state_e;

  localparam int CHA_LSB  = 0;
  localparam int CHA_OVF  = 12;
  localparam int CHB_LSB  = 13;
  localparam int CHB_OVF  = 25;
  localparam int SAMPLE_W = 12;
  localparam int WORD_W   = 26;

  function automatic logic [SAMPLE_W-1:0] cha_sample(input logic [WORD_W-1:0] w);
    return w[CHA_LSB +: SAMPLE_W];
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one read port with a
// registered (1-cycle) read, written so that it maps onto block RAM.
module capture_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_W     = 26
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WORD_W-1:0]     wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WORD_W-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // No reset on the array or read register so the tools keep it in block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/adc_trigger_capture.sv
// Pre-/post-trigger circular capture of paired ADC words with an
// oldest-first valid/ready drain of the complete window.
module adc_trigger_capture
  import adc_capture_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int PRETRIG    = 256
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [WORD_W-1:0]     ADC_DATA,
  input  logic [SAMPLE_W-1:0]   THRESHOLD,
  input  logic                  ARM,
  input  logic                  FORCE_TRIG,
  input  logic                  ABORT,
  output logic                  BUSY,
  output logic                  TRIGGERED,
  output logic [ADDR_WIDTH-1:0] TRIG_ADDR,
  output logic [WORD_W-1:0]     RD_DATA,
  output logic                  RD_VALID,
  input  logic                  RD_READY,
  output logic                  DONE
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PRE_A     = ADDR_WIDTH'(PRETRIG);
  localparam logic [ADDR_WIDTH-1:0] PRE_LAST  = ADDR_WIDTH'(PRETRIG - 1);
  localparam logic [ADDR_WIDTH-1:0] POST_LOAD = ADDR_WIDTH'(DEPTH - PRETRIG - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [WORD_W-1:0]     d1_q, d1_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, fill_cnt_q, fill_cnt_d;
  logic [ADDR_WIDTH-1:0] post_cnt_q, post_cnt_d, rptr_q, rptr_d;
  logic [ADDR_WIDTH-1:0] rcnt_q, rcnt_d, trig_addr_q, trig_addr_d;
  logic                  triggered_q, triggered_d, busy_q, busy_d;
  logic [WORD_W-1:0]     rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d, done_q, done_d;
  logic                  start_q, start_d, ram_vld_q, ram_vld_d;
  logic                  we_s, re_s, accept_s, trig_s;
  logic [WORD_W-1:0]     ram_rdata_s;

  capture_ram #(.ADDR_WIDTH(ADDR_WIDTH), .WORD_W(WORD_W)) u_ram (
    .clk   (CLK),
    .we    (we_s),
    .waddr (wptr_q),
    .wdata (d1_q),
    .re    (re_s),
    .raddr (rptr_q),
    .rdata (ram_rdata_s)
  );

  // Next-state, pointer and readout-pipeline logic.
  always_comb begin
    state_d     = state_q;
    d1_d        = ADC_DATA;
    wptr_d      = wptr_q;
    fill_cnt_d  = fill_cnt_q;
    post_cnt_d  = post_cnt_q;
    rptr_d      = rptr_q;
    rcnt_d      = rcnt_q;
    trig_addr_d = trig_addr_q;
    triggered_d = triggered_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    done_d      = 1'b0;
    start_d     = 1'b0;
    ram_vld_d   = 1'b0;
    we_s        = 1'b0;
    re_s        = 1'b0;
    accept_s    = rd_valid_q && RD_READY;
    trig_s      = (cha_sample(d1_q) >= THRESHOLD) || FORCE_TRIG;

    case (state_q)
      IDLE: begin
        if (ARM) begin
          wptr_d     = '0;
          fill_cnt_d = '0;
          rcnt_d     = '0;
          state_d    = (PRETRIG == 0) ? ARMED : FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        we_s       = 1'b1;
        wptr_d     = wptr_q + ONE_A;
        fill_cnt_d = fill_cnt_q + ONE_A;
        if (fill_cnt_q == PRE_LAST) begin
          state_d = ARMED;
        end else begin
          state_d = FILL;
        end
      end
      ARMED: begin
        we_s   = 1'b1;
        wptr_d = wptr_q + ONE_A;
        if (trig_s) begin
          trig_addr_d = wptr_q;
          triggered_d = 1'b1;
          rptr_d      = wptr_q - PRE_A;
          post_cnt_d  = POST_LOAD;
          if (POST_LOAD == '0) begin
            state_d = READ;
            start_d = 1'b1;
          end else begin
            state_d = POST;
          end
        end else begin
          state_d = ARMED;
        end
      end
      POST: begin
        we_s       = 1'b1;
        wptr_d     = wptr_q + ONE_A;
        post_cnt_d = post_cnt_q - ONE_A;
        if (post_cnt_q == ONE_A) begin
          state_d = READ;
          start_d = 1'b1;
        end else begin
          state_d = POST;
        end
      end
      READ: begin
        // One address issue per word: at READ entry, then on each non-final acceptance.
        if (accept_s) begin
          rd_valid_d = 1'b0;
          rcnt_d     = rcnt_q + ONE_A;
          if (rcnt_q == LAST_IDX) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            triggered_d = 1'b0;
          end else begin
            re_s      = 1'b1;
            rptr_d    = rptr_q + ONE_A;
            ram_vld_d = 1'b1;
          end
        end else if (start_q) begin
          re_s      = 1'b1;
          rptr_d    = rptr_q + ONE_A;
          ram_vld_d = 1'b1;
        end else if (ram_vld_q) begin
          rd_data_d  = ram_rdata_s;
          rd_valid_d = 1'b1;
        end else begin
          rd_valid_d = rd_valid_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (ABORT) begin
      state_d     = IDLE;
      rd_valid_d  = 1'b0;
      triggered_d = 1'b0;
      done_d      = 1'b0;
      start_d     = 1'b0;
      ram_vld_d   = 1'b0;
    end else begin
      state_d = state_d;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      d1_q        <= '0;
      wptr_q      <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
      rptr_q      <= '0;
      rcnt_q      <= '0;
      trig_addr_q <= '0;
      triggered_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
      ram_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      d1_q        <= d1_d;
      wptr_q      <= wptr_d;
      fill_cnt_q  <= fill_cnt_d;
      post_cnt_q  <= post_cnt_d;
      rptr_q      <= rptr_d;
      rcnt_q      <= rcnt_d;
      trig_addr_q <= trig_addr_d;
      triggered_q <= triggered_d;
      busy_q      <= busy_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      start_q     <= start_d;
      ram_vld_q   <= ram_vld_d;
    end
  end

  assign BUSY      = busy_q;
  assign TRIGGERED = triggered_q;
  assign TRIG_ADDR = trig_addr_q;
  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;
  assign DONE      = done_q;

endmodule

// File: doc/adc_trigger_capture.md
# adc_trigger_capture

Pre-/post-trigger capture buffer for the 26-bit paired ADC words delivered each CLK by the DDR synchronizer stage. Continuously records the sample stream into a circular RAM once armed, fires on a channel-A threshold crossing or a forced trigger, completes the post-trigger window, then drains the whole window oldest-first over a valid/ready read port. It is the first CLK-domain consumer of the synchronized ADC data and feeds the readout/DMA logic.

## Interface
- ADDR_WIDTH, 10: buffer depth DEPTH = 2^ADDR_WIDTH words.
- PRETRIG, 256: number of words stored before the trigger word; legal range 0..DEPTH-1.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- ADC_DATA  in  26  [11:0] ch A data, [12] ch A overflow, [24:13] ch B data, [25] ch B overflow; new word every CLK.
- THRESHOLD  in  12  unsigned trigger level for ch A data.
- ARM  in  1  start capture; honoured only in IDLE.
- FORCE_TRIG  in  1  software trigger; honoured only in ARMED.
- ABORT  in  1  return to IDLE from any state.
- BUSY  out  1  high in FILL, ARMED, POST, READ.
- TRIGGERED  out  1  high from trigger acceptance until return to IDLE.
- TRIG_ADDR  out  ADDR_WIDTH  RAM address of the trigger word.
- RD_DATA  out  26  readout word.
- RD_VALID  out  1  RD_DATA valid.
- RD_READY  in  1  consumer accepts word when RD_VALID && RD_READY.
- DONE  out  1  one-cycle pulse after the last word is accepted.

## Operation
- Reset: state IDLE; BUSY, TRIGGERED, RD_VALID, DONE = 0; RD_DATA, TRIG_ADDR, write pointer, counters = 0.
- Input stage: ADC_DATA registered once (D1) every cycle regardless of state; RAM write and trigger compare both act on D1.
- States: IDLE, FILL, ARMED, POST, READ.
- IDLE: ARM=1 -> FILL (or ARMED if PRETRIG=0); write pointer and fill counter cleared.
- FILL: write D1 each cycle at wptr, wptr++ (wraps mod DEPTH); after PRETRIG writes -> ARMED. Triggers ignored.
- ARMED: write D1 each cycle. Trigger = D1[11:0] >= THRESHOLD, or FORCE_TRIG. On trigger: the word written that cycle is the trigger word, TRIG_ADDR <= wptr, TRIGGERED <= 1, post counter loaded with DEPTH-PRETRIG-1 -> POST (READ directly if that count is 0). Overflow bits do not trigger.
- POST: write D1 each cycle, decrement counter; on reaching 0 (last write this cycle) -> READ. Writes stop.
- READ: read pointer starts at TRIG_ADDR - PRETRIG (mod DEPTH); DEPTH words returned in address order, wrapping. Word index PRETRIG of the readout is the trigger word.
- Read handshake: RD_DATA holds and RD_VALID stays high until accepted; RD_DATA must not change while RD_VALID=1. After each acceptance RD_VALID is low exactly one cycle, then the next word is valid (throughput 1 word / 2 cycles). After the DEPTH-th acceptance: RD_VALID=0, DONE pulses, TRIGGERED=0 -> IDLE.
- ABORT (any state, priority over all other inputs): next cycle IDLE, RD_VALID=0, TRIGGERED=0, no DONE.
- RST_N low mid-operation: identical to reset values next cycle; RAM contents undefined thereafter.
- ARM outside IDLE and FORCE_TRIG outside ARMED: ignored.

## Timing
- ADC word at ADC_DATA in cycle n is written/compared in cycle n+1.
- ARM sampled in cycle c: BUSY=1 from cycle c+1; first RAM write in c+1 (of word presented in c).
- Trigger compared in cycle t: TRIGGERED=1 and TRIG_ADDR valid from t+1.
- Last post-trigger write in cycle p: state READ in p+1; first RD_VALID at p+3 (address issue, RAM latency 1, output register).
- Acceptance in cycle a: RD_VALID=0 in a+1, next word valid in a+2. DONE high in a+1 for the last word.
- Minimum trigger-to-first-read latency: DEPTH-PRETRIG+2 cycles.

## Structure
- Package adc_capture_pkg: state enum (IDLE, FILL, ARMED, POST, READ); field constants CHA_LSB=0, CHA_OVF=12, CHB_LSB=13, CHB_OVF=25, SAMPLE_W=12, WORD_W=26.
- Sub-module capture_ram: simple dual-port RAM, WORD_W x DEPTH, one write port, one read port with 1-cycle registered read; infers block RAM.
- Top holds input register, FSM, pointers, counters, output register.

## Test plan
- ADDR_WIDTH=4, PRETRIG=4, ADC_DATA = ramp (ch A = cycle index), THRESHOLD=40 -> trigger on ch A value 40; readout 16 words = values 36..51 in order, TRIG_ADDR consistent, DONE once.
- Same, THRESHOLD=0 from ARM -> trigger ignored during FILL; first accepted trigger is the 5th written word (index 4), readout starts at first written word.
- FORCE_TRIG in ARMED with THRESHOLD=4095, flat data 100 -> trigger that cycle; 16 words all 100 with correct overflow bits carried through.
- RD_READY randomly toggled -> RD_DATA stable while RD_VALID=1 and not accepted; exactly 16 acceptances; one-cycle gap after each.
- ABORT during POST, then RST_N low during READ -> next cycle IDLE, all outputs at reset values, no DONE; subsequent ARM completes a normal capture.
- PRETRIG=0 and PRETRIG=15 -> trigger word at readout index 0 and 15 respectively; pointer wrap across address 15->0 verified.
